regfile_wport_sched: RTL and testbench



---
 rtl/regfile_ctrl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/regfile_wport_sched.sv | 104 ++++++++++
 tb/tb_regfile_wport_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and helpers for the register-file write-port scheduler.
// Holds the scheduler FSM encoding and the round-robin pointer step.
package regfile_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    INIT,
    DONE
  } rf_sched_state_t;

  // Pointer value that follows a winner at index ptr among n requesters.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Grants the first active request found at or after ptr, wrapping around.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  int   idx;
  logic found;

  // NOTE: every output gets a default before the search loop, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wport_sched.sv
// Shares one registered register-file write port among N_REQ requesters
// and sweeps every register to INIT_VALUE on request.
module regfile_wport_sched
  import regfile_ctrl_pkg::*;
#(
  parameter  int               WIDTH      = 32,
  parameter  int               N_REG      = 32,
  parameter  int               N_REQ      = 4,
  parameter  logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int               AW         = (N_REG > 1) ? $clog2(N_REG) : 1,
  localparam int               PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][AW-1:0]    req_addr,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
  input  logic                        init_start,
  output logic                        init_busy,
  output logic                        init_done,
  output logic                        err_addr,
  output logic                        rf_wen,
  output logic [AW-1:0]               rf_waddr,
  output logic [WIDTH-1:0]            rf_wdata
);

  rf_sched_state_t state;
  logic [PW-1:0]   rr_ptr;
  logic [AW-1:0]   sweep_addr;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            xfer;
  logic            addr_ok;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A pending init_start outranks every requester in the cycle it arrives.
  assign req_ready = (!rst && state == RUN && !init_start) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign addr_ok   = int'(req_addr[gnt_idx]) < N_REG;

  // NOTE: all state lives here and uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      rr_ptr     <= '0;
      sweep_addr <= '0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      init_busy  <= 1'b0;
      init_done  <= 1'b0;
      err_addr   <= 1'b0;
    end else begin
      rf_wen    <= 1'b0;
      init_done <= 1'b0;
      err_addr  <= 1'b0;
      case (state)
        RUN: begin
          if (init_start) begin
            state     <= INIT;
            init_busy <= 1'b1;
          end else if (xfer) begin
            rr_ptr <= PW'(rr_next(int'(gnt_idx), N_REQ));
            if (addr_ok) begin
              rf_wen   <= 1'b1;
              rf_waddr <= req_addr[gnt_idx];
              rf_wdata <= req_data[gnt_idx];
            end else begin
              err_addr <= 1'b1;
            end
          end
        end
        INIT: begin
          rf_wen   <= 1'b1;
          rf_waddr <= sweep_addr;
          rf_wdata <= INIT_VALUE;
          if (sweep_addr == AW'(N_REG - 1)) begin
            sweep_addr <= '0;
            state      <= DONE;
            init_done  <= 1'b1;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        DONE: begin
          state     <= RUN;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= RUN;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wport_sched.sv
// Directed bench for regfile_wport_sched: N_REQ=4, N_REG=6, INIT_VALUE=0x3C.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_regfile_wport_sched;

  localparam int WIDTH = 32;
  localparam int N_REG = 6;
  localparam int N_REQ = 4;
  localparam int AW    = 3;
  localparam logic [WIDTH-1:0] IV = 32'h3C;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][AW-1:0]    req_addr;
  logic [N_REQ-1:0][WIDTH-1:0] req_data;
  logic                        init_start;
  logic                        init_busy;
  logic                        init_done;
  logic                        err_addr;
  logic                        rf_wen;
  logic [AW-1:0]               rf_waddr;
  logic [WIDTH-1:0]            rf_wdata;

  int checks = 0;
  int errors = 0;

  regfile_wport_sched #(
    .WIDTH(WIDTH), .N_REG(N_REG), .N_REQ(N_REQ), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .err_addr(err_addr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; init_start = 1'b0;
    req_addr = '0; req_data = '0;
    #3;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    tick();
    checks++; if ({rf_wen, init_busy, init_done, err_addr} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got wen/busy/done/err=%b expected 0000", {rf_wen, init_busy, init_done, err_addr}); end
    checks++; if (rf_waddr !== '0 || rf_wdata !== '0) begin errors++;
      $display("FAIL reset_wport: got addr=%0d data=%h expected 0/0", rf_waddr, rf_wdata); end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_write();
    req_valid = 4'b0100; req_addr[2] = 3'd5; req_data[2] = 32'hA5;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL basic_ready: got %b expected 0100", req_ready); end
    tick(); req_valid = '0;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 32'hA5) begin errors++;
      $display("FAIL basic_write: got wen=%b addr=%0d data=%h expected 1/5/a5", rf_wen, rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_wen !== 1'b0 || rf_waddr !== 3'd5 || rf_wdata !== 32'hA5) begin errors++;
      $display("FAIL basic_hold: got wen=%b addr=%0d data=%h expected 0/5/a5", rf_wen, rf_waddr, rf_wdata); end
    // Pointer sits at 3 now; a lone req 3 wins and wraps it back to 0.
    req_valid = 4'b1000; req_addr[3] = 3'd1; req_data[3] = 32'h1234_5678;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready: got %b expected 1000", req_ready); end
    tick(); req_valid = '0;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 32'h1234_5678) begin errors++;
      $display("FAIL wrap_write: got wen=%b addr=%0d data=%h expected 1/1/12345678", rf_wen, rf_waddr, rf_wdata); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[i] = AW'(i); req_data[i] = 32'h100 + i;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
      tick();
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== AW'(k % 4) || rf_wdata !== 32'h100 + (k % 4)) begin errors++;
        $display("FAIL fair_write[%0d]: got wen=%b addr=%0d data=%h expected 1/%0d/%h", k, rf_wen, rf_waddr, rf_wdata, k % 4, 32'h100 + (k % 4)); end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_init_sweep();
    req_valid = 4'b0010; req_addr[1] = 3'd2; req_data[1] = 32'hBEEF;
    init_start = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL init_prio_ready: got %b expected 0000", req_ready); end
    tick(); init_start = 1'b0;
    checks++; if (init_busy !== 1'b1 || rf_wen !== 1'b0) begin errors++;
      $display("FAIL init_enter: got busy=%b wen=%b expected 1/0", init_busy, rf_wen); end
    for (int a = 0; a < N_REG; a++) begin
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL init_ready[%0d]: got %b expected 0000", a, req_ready); end
      tick();
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== AW'(a) || rf_wdata !== IV || init_done !== (a == N_REG - 1)) begin errors++;
        $display("FAIL init_write[%0d]: got wen=%b addr=%0d data=%h done=%b expected 1/%0d/3c/%b", a, rf_wen, rf_waddr, rf_wdata, init_done, a, a == N_REG - 1); end
    end
    checks++; if (req_ready !== 4'b0 || init_busy !== 1'b1) begin errors++;
      $display("FAIL init_done_cycle: got ready=%b busy=%b expected 0000/1", req_ready, init_busy); end
    tick();
    checks++; if (init_done !== 1'b0 || init_busy !== 1'b0 || rf_wen !== 1'b0 || req_ready !== 4'b0010) begin errors++;
      $display("FAIL init_exit: got done=%b busy=%b wen=%b ready=%b expected 0/0/0/0010", init_done, init_busy, rf_wen, req_ready); end
    tick(); req_valid = '0;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 32'hBEEF) begin errors++;
      $display("FAIL init_after_write: got wen=%b addr=%0d data=%h expected 1/2/beef", rf_wen, rf_waddr, rf_wdata); end
  endtask

  task automatic test_out_of_range();
    // Pointer is at 2; req 0 alone still wins and moves the pointer to 1.
    req_valid = 4'b0001; req_addr[0] = 3'd7; req_data[0] = 32'hBAD;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL oor_ready: got %b expected 0001", req_ready); end
    tick(); req_valid = '0;
    checks++; if (rf_wen !== 1'b0 || err_addr !== 1'b1 || rf_waddr !== 3'd2) begin errors++;
      $display("FAIL oor_err: got wen=%b err=%b addr=%0d expected 0/1/2", rf_wen, err_addr, rf_waddr); end
    tick();
    checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL oor_pulse: got %b expected 0", err_addr); end
    req_valid = 4'b0011; req_addr[0] = 3'd3; req_data[0] = 32'h33; req_addr[1] = 3'd4; req_data[1] = 32'h44;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL oor_ptr_ready: got %b expected 0010", req_ready); end
    tick(); req_valid = '0;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 3'd4 || rf_wdata !== 32'h44) begin errors++;
      $display("FAIL oor_ptr_write: got wen=%b addr=%0d data=%h expected 1/4/44", rf_wen, rf_waddr, rf_wdata); end
    // Bring the pointer from 2 back to 0 for the reset scenario.
    req_valid = 4'b0100; req_addr[2] = 3'd0; tick();
    req_valid = 4'b1000; req_addr[3] = 3'd0; tick();
    req_valid = '0; tick();
  endtask

  task automatic test_reset_mid_sweep();
    int done_seen = 0;
    init_start = 1'b1;
    tick(); init_start = 1'b0;
    tick(); tick(); tick();
    checks++; if (rf_waddr !== 3'd2 || init_busy !== 1'b1) begin errors++;
      $display("FAIL midrst_pos: got addr=%0d busy=%b expected 2/1", rf_waddr, init_busy); end
    rst = 1'b1;
    #1;
    checks++; if ({rf_wen, init_busy, init_done, err_addr} !== 4'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin errors++;
      $display("FAIL midrst_async: got wen/busy/done/err=%b addr=%0d data=%h expected 0000/0/0", {rf_wen, init_busy, init_done, err_addr}, rf_waddr, rf_wdata); end
    tick(); tick();
    rst = 1'b0;
    req_valid = 4'b1000; req_addr[3] = 3'd4; req_data[3] = 32'h5A5A;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL midrst_ready: got %b expected 1000", req_ready); end
    tick(); req_valid = '0;
    if (init_done) done_seen++;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 3'd4 || rf_wdata !== 32'h5A5A) begin errors++;
      $display("FAIL midrst_write: got wen=%b addr=%0d data=%h expected 1/4/5a5a", rf_wen, rf_waddr, rf_wdata); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (init_done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen); end
  endtask

  task automatic test_withdrawal();
    int bad = 0;
    req_valid = 4'b0010; req_addr[1] = 3'd4; req_data[1] = 32'hDEAD_BEEF;
    init_start = 1'b1;
    tick(); init_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) req_valid = '0;
      #1;
      if (req_ready[1] || (rf_wen && rf_wdata === 32'hDEAD_BEEF)) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL withdraw: got %0d bad cycles expected 0", bad); end
    checks++; if (init_busy !== 1'b0 || req_ready !== 4'b0) begin errors++;
      $display("FAIL withdraw_idle: got busy=%b ready=%b expected 0/0000", init_busy, req_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_fairness();
    test_init_sweep();
    test_out_of_range();
    test_reset_mid_sweep();
    test_withdrawal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
